// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC frame capture block.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    IDLE      = 2'd1,
    CAPTURE   = 2'd2,
    DRAIN     = 2'd3
  } cap_state_e;

  localparam int DEF_DATA_W          = 8;
  localparam int DEF_FRAME_LEN       = 1024;
  localparam int DEF_LOCK_STABLE_CYC = 1024;
  localparam int DEF_DECIM_W         = 8;

  // Width of the beat index counter; holds 0..frame_len-1.
  function automatic int cnt_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/adc_frame_capture_if.sv
// Valid/ready sample stream from the frame capture block to the FFT stage.
interface adc_frame_capture_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lock_qualifier.sv
// Synchronizes the raw PLL lock and asserts lock_ok only after it has been
// continuously high for LOCK_STABLE_CYC sample clocks.
module lock_qualifier
  import adc_cap_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_ok
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);

  logic              sync_p0;
  logic              sync_p1;
  logic [STAB_W-1:0] stab_cnt;
  logic              stable;

  assign stable = (stab_cnt == STAB_W'(LOCK_STABLE_CYC));

  // Stage p0/p1: two-flop synchronizer, then saturating stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stab_cnt <= '0;
    end else begin
      sync_p0 <= pll_lock;
      sync_p1 <= sync_p0;
      if (!sync_p1)
        stab_cnt <= '0;
      else if (!stable)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Drops in the same cycle the synchronized lock goes low.
  assign lock_ok = sync_p1 && stable;

endmodule

// File: rtl/adc_frame_capture.sv
// Captures one FRAME_LEN-sample ADC frame (optionally decimated) and streams it
// out over valid/ready. Build macro ADC_TEST_RAMP_EN swaps ADC data for a ramp.
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int FRAME_LEN       = DEF_FRAME_LEN,
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int DECIM_W         = DEF_DECIM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_lock,
  input  logic [DATA_W-1:0]    adc_data,
  input  logic                 start,
  input  logic [DECIM_W-1:0]   decim,
  adc_frame_capture_if.master  m,
  output logic                 lock_ok,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 lock_err
);

  localparam int CNT_W = cnt_w(FRAME_LEN);

  cap_state_e         state_q;
  logic [DATA_W-1:0]  adc_q;
  logic [DATA_W-1:0]  tdata_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic [CNT_W-1:0]   smp_cnt;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dec_cnt;

  logic hs;
  logic tick;
  logic start_acc;
  logic can_load;
  logic last_beat;

  lock_qualifier #(
    .LOCK_STABLE_CYC(LOCK_STABLE_CYC)
  ) u_lock_qualifier (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .lock_ok  (lock_ok)
  );

  assign hs        = tvalid_q && m.tready;
  assign tick      = lock_ok && (state_q == CAPTURE) && (dec_cnt == '0);
  assign start_acc = lock_ok && (state_q == IDLE) && start;
  assign can_load  = !tvalid_q || m.tready;
  assign last_beat = (smp_cnt == CNT_W'(FRAME_LEN - 1));

  // Stage p0: sample source register (adc_q).
`ifdef ADC_TEST_RAMP_EN
  logic unused_adc_data;
  assign unused_adc_data = ^adc_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      adc_q <= '0;
    else if (start_acc)
      adc_q <= '0;
    else if (tick)
      adc_q <= adc_q + 1'b1;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      adc_q <= '0;
    else
      adc_q <= adc_data;
  end
`endif

  // Stage p1: control FSM and output beat register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      smp_cnt  <= '0;
      decim_q  <= '0;
      dec_cnt  <= '0;
      overflow <= 1'b0;
      lock_err <= 1'b0;
    end else if (!lock_ok) begin
      state_q  <= WAIT_LOCK;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      if (state_q == CAPTURE || state_q == DRAIN)
        lock_err <= 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: state_q <= IDLE;
        IDLE: begin
          if (start) begin
            decim_q  <= decim;
            smp_cnt  <= '0;
            dec_cnt  <= '0;
            overflow <= 1'b0;
            lock_err <= 1'b0;
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
          dec_cnt <= (dec_cnt == '0) ? decim_q : dec_cnt - 1'b1;
          if (tick) begin
            if (can_load) begin
              tdata_q  <= adc_q;
              tvalid_q <= 1'b1;
              tlast_q  <= last_beat;
              smp_cnt  <= smp_cnt + 1'b1;
              if (last_beat)
                state_q <= DRAIN;
            end else begin
              // Output still full: drop the sample and abort the frame.
              overflow <= 1'b1;
              state_q  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  assign m.tdata    = tdata_q;
  assign m.tvalid   = tvalid_q;
  assign m.tlast    = tlast_q;
  assign busy       = (state_q == CAPTURE) || (state_q == DRAIN);
  assign frame_done = lock_ok && (state_q == DRAIN) && hs && tlast_q;

endmodule
